st_pkt_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one `st_pkt_intf` downstream link between `N_INPUTS` upstream `st_pkt_intf` packet sources. Ownership is granted on a start-of-packet beat and held until the owner's end-of-packet beat is accepted, so packets are never interleaved. The arbiter sits between independent packet producers (e.g. serializer lanes) and a single packet consumer.

---
 rtl/st_pkt_arb_pkg.sv | 19 +
 rtl/st_pkt_arbiter_if.sv | 34 +++
 rtl/st_pkt_arbiter_rr_pick.sv | 33 +++
 rtl/st_pkt_arbiter.sv | 148 ++++++++++++++
 tb/tb_st_pkt_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/st_pkt_arb_pkg.sv
// Shared types and width helpers for the packet arbiter and its stream interface.
package st_pkt_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_t;

  // Index width for an n-way choice.
  function automatic int unsigned rr_idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  // Byte-count field width for a data bus of the given bit width.
  function automatic int unsigned len_w(input int unsigned width);
    return (width > 15) ? int'($clog2(width / 8)) : 1;
  endfunction

endpackage

// File: rtl/st_pkt_arbiter_if.sv
// Packet stream link: valid/ready handshake with sop/eop framing and a byte-count field.
interface st_pkt_intf
  import st_pkt_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned LEN_W = len_w(WIDTH);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len;
  logic             sop;
  logic             eop;

  modport master (
    output valid,
    output data,
    output len,
    output sop,
    output eop,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  len,
    input  sop,
    input  eop,
    output ready
  );

endinterface

// File: rtl/st_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from last+1.
module rr_pick
  import st_pkt_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [rr_idx_w(N)-1:0] last,
  output logic                   found,
  output logic [rr_idx_w(N)-1:0] idx
);
  localparam int unsigned IDX_W = rr_idx_w(N);

  int unsigned cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    // k = N wraps back onto last itself, so a lone requester can win again.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(last) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/st_pkt_arbiter.sv
// Packet-level round-robin arbiter: N packet sources share one downstream link,
// ownership granted on sop and held until the owner's eop beat is accepted.
module st_pkt_arbiter
  import st_pkt_arb_pkg::*;
#(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  st_pkt_intf.slave           s_in [N_INPUTS],
  st_pkt_intf.master          m_out,
  output logic [N_INPUTS-1:0] grant_o,
  output logic                err_o
);
  localparam int unsigned IDX_W = rr_idx_w(N_INPUTS);
  localparam int unsigned LEN_W = len_w(WIDTH);

  logic [N_INPUTS-1:0]            in_valid;
  logic [N_INPUTS-1:0]            in_sop;
  logic [N_INPUTS-1:0]            in_eop;
  logic [N_INPUTS-1:0][WIDTH-1:0] in_data;
  logic [N_INPUTS-1:0][LEN_W-1:0] in_len;

  logic             out_valid;
  logic             out_sop;
  logic             out_eop;
  logic [WIDTH-1:0] out_data;
  logic [LEN_W-1:0] out_len;

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [N_INPUTS-1:0] grant_q, grant_d;
  logic                first_q, first_d;
  logic                err_q, err_d;

  logic [N_INPUTS-1:0] req;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                xfer;

  // Interface arrays only take constant indices, so flatten them here.
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_in
    assign in_valid[i]    = s_in[i].valid;
    assign in_sop[i]      = s_in[i].sop;
    assign in_eop[i]      = s_in[i].eop;
    assign in_data[i]     = s_in[i].data;
    assign in_len[i]      = s_in[i].len;
    assign s_in[i].ready  = grant_q[i] & m_out.ready;
  end

  assign req = in_valid & in_sop;

  rr_pick #(
    .N (N_INPUTS)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    out_len   = '0;
    if (state_q == LOCKED) begin
      out_valid = in_valid[owner_q];
      out_sop   = in_sop[owner_q];
      out_eop   = in_eop[owner_q];
      out_data  = in_data[owner_q];
      out_len   = in_len[owner_q];
    end
  end

  assign m_out.valid = out_valid;
  assign m_out.sop   = out_sop;
  assign m_out.eop   = out_eop;
  assign m_out.data  = out_data;
  assign m_out.len   = out_len;

  assign xfer = out_valid & m_out.ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    first_d = first_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // A source showing data without sop while unowned is mid-packet garbage.
        if (|(in_valid & ~in_sop)) begin
          err_d = 1'b1;
        end
        if (pick_found) begin
          state_d = LOCKED;
          owner_d = pick_idx;
          grant_d = N_INPUTS'(1) << pick_idx;
          first_d = 1'b1;
        end
      end
      LOCKED: begin
        if (xfer) begin
          first_d = 1'b0;
          if (out_sop && !first_q) begin
            err_d = 1'b1;
          end
          if (out_eop) begin
            state_d = IDLE;
            last_d  = owner_q;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_INPUTS - 1);
      grant_q <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign grant_o = grant_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_st_pkt_arbiter.sv
// Scoreboard bench for st_pkt_arbiter: per-input source queues, expected beats queued in grant order.
module tb_st_pkt_arbiter;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  len;
    logic        sop;
    logic        eop;
    int          src;
  } beat_t;

  logic clk;
  logic rst;
  logic [3:0] grant_o;
  logic       err_o;

  st_pkt_intf #(.WIDTH(32)) s_in [4] ();
  st_pkt_intf #(.WIDTH(32)) m_out ();

  logic [3:0]       drv_valid;
  logic [3:0]       drv_sop;
  logic [3:0]       drv_eop;
  logic [3:0][31:0] drv_data;
  logic [3:0][1:0]  drv_len;
  logic [3:0]       mon_ready;
  logic             out_ready;

  for (genvar g = 0; g < 4; g++) begin : g_src
    assign s_in[g].valid = drv_valid[g];
    assign s_in[g].sop   = drv_sop[g];
    assign s_in[g].eop   = drv_eop[g];
    assign s_in[g].data  = drv_data[g];
    assign s_in[g].len   = drv_len[g];
    assign mon_ready[g]  = s_in[g].ready;
  end
  assign m_out.ready = out_ready;

  st_pkt_arbiter #(
    .N_INPUTS (4),
    .WIDTH    (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_in    (s_in),
    .m_out   (m_out),
    .grant_o (grant_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t srcq [4][$];
  beat_t exp_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    pkt_id   = 0;

  logic [3:0]  smp_grant;
  logic [3:0]  smp_rdy;
  logic        smp_err;
  logic        smp_valid;
  logic [31:0] smp_data;
  logic [3:0]  smp_flags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic add_pkt(input int src, input int nbeats, input int badsop);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.data = {8'(src), 8'(pkt_id), 16'(k)};
      b.sop  = (k == 0) || (k == badsop);
      b.eop  = (k == nbeats - 1);
      b.len  = b.eop ? 2'd1 : 2'd3;
      b.src  = src;
      srcq[src].push_back(b);
      exp_q.push_back(b);
    end
    pkt_id++;
  endtask

  task automatic apply_drive();
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() != 0) begin
        drv_valid[i] = 1'b1;
        drv_sop[i]   = srcq[i][0].sop;
        drv_eop[i]   = srcq[i][0].eop;
        drv_data[i]  = srcq[i][0].data;
        drv_len[i]   = srcq[i][0].len;
      end else begin
        drv_valid[i] = 1'b0;
        drv_sop[i]   = 1'b0;
        drv_eop[i]   = 1'b0;
        drv_data[i]  = '0;
        drv_len[i]   = '0;
      end
    end
  endtask

  // One cycle: drive at posedge+1, sample and score at negedge, retire source beats after the edge.
  task automatic step();
    logic [3:0] fire;
    beat_t      e;
    apply_drive();
    @(negedge clk);
    smp_grant = grant_o;
    smp_rdy   = mon_ready;
    smp_err   = err_o;
    smp_valid = m_out.valid;
    smp_data  = m_out.data;
    smp_flags = {m_out.len, m_out.sop, m_out.eop};
    fire      = drv_valid & smp_rdy;
    check("nonowner_ready", 32'(smp_rdy & ~smp_grant), 32'd0);
    check("unowned_valid", 32'(smp_valid && (smp_grant == 4'd0)), 32'd0);
    if (smp_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("exp_avail", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", smp_data, e.data);
        check("beat_flags", 32'(smp_flags), 32'({e.len, e.sop, e.eop}));
        check("beat_grant", 32'(smp_grant), 32'd1 << e.src);
        check("beat_src_fire", 32'(fire), 32'd1 << e.src);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire[i] && srcq[i].size() != 0) begin
        void'(srcq[i].pop_front());
      end
    end
  endtask

  task automatic drain(input string tag, input int want_cyc);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      step();
      cyc++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(want_cyc));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    exp_q.delete();
    out_ready = 1'b1;
    apply_drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    apply_drive();
    do_reset();
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_valid", 32'(m_out.valid), 32'd0);
    check("rst_ready", 32'(mon_ready), 32'd0);
    check("rst_data", m_out.data, 32'd0);

    // 3-beat packet on input 2.
    add_pkt(2, 3, -1);
    step();
    check("p2_bubble_grant", 32'(smp_grant), 32'd0);
    step();
    check("p2_grant", 32'(smp_grant), 32'b0100);
    drain("p2", 2);
    step();
    check("p2_idle_after", 32'(smp_grant), 32'd0);
    // last_owner = 2, so input 3 beats input 0.
    add_pkt(3, 2, -1);
    add_pkt(0, 2, -1);
    drain("after2", 6);

    // All inputs continuously requesting 2-beat packets.
    do_reset();
    add_pkt(0, 2, -1);
    add_pkt(1, 2, -1);
    add_pkt(2, 2, -1);
    add_pkt(3, 2, -1);
    add_pkt(0, 2, -1);
    drain("rr4", 15);

    // Backpressure on owner 1 while input 2 waits.
    do_reset();
    add_pkt(1, 3, -1);
    add_pkt(2, 2, -1);
    step();
    step();
    check("bp_grant", 32'(smp_grant), 32'b0010);
    check("bp_rdy_on", 32'(smp_rdy), 32'b0010);
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      check("bp_hold_valid", 32'(smp_valid), 32'd1);
      check("bp_hold_data", smp_data, exp_q[0].data);
      check("bp_rdy_off", 32'(smp_rdy), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_rdy_back", 32'(smp_rdy), 32'b0010);
    drain("bp", 4);

    // Single-beat packets on 0 and 3.
    do_reset();
    add_pkt(0, 1, -1);
    add_pkt(3, 1, -1);
    drain("single", 4);

    // Input 1 shows valid without sop while idle.
    do_reset();
    begin
      beat_t b;
      b.data = 32'hbad0_0001;
      b.len  = 2'd3;
      b.sop  = 1'b0;
      b.eop  = 1'b0;
      b.src  = 1;
      srcq[1].push_back(b);
    end
    step();
    check("nosop_err_pre", 32'(smp_err), 32'd0);
    step();
    check("nosop_err", 32'(smp_err), 32'd1);
    check("nosop_grant", 32'(smp_grant), 32'd0);
    add_pkt(2, 2, -1);
    drain("nosop_other", 3);
    check("nosop_stalled", 32'(srcq[1].size()), 32'd1);
    step();
    check("nosop_err_sticky", 32'(smp_err), 32'd1);

    // Owner repeats sop mid-packet.
    do_reset();
    add_pkt(0, 3, 1);
    step();
    check("dupsop_err_pre", 32'(smp_err), 32'd0);
    drain("dupsop", 3);
    check("dupsop_err", 32'(smp_err), 32'd1);

    // Reset on beat 2 of a 4-beat packet.
    do_reset();
    add_pkt(0, 4, -1);
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_grant", 32'(grant_o), 32'd0);
    check("midrst_valid", 32'(m_out.valid), 32'd0);
    check("midrst_ready", 32'(mon_ready), 32'd0);
    for (int i = 0; i < 4; i++) srcq[i].delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    add_pkt(0, 2, -1);
    add_pkt(2, 2, -1);
    drain("postrst", 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
